multicycle_control_unit: RTL and testbench

- Multi-cycle RISC-V control FSM that replaces the single-cycle main decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, with a ready handshake to a variable-latency memory.
- Supports R-type, I-type ALU, ld, sd, beq and (optionally) jal.
- Flags illegal opcodes and memory timeouts through a sticky trap state.

---
 rtl/multicycle_control_unit_pkg.sv | 58 +++++
 rtl/multicycle_control_unit_if.sv | 36 +++
 rtl/multicycle_control_unit_mem_wait_timer.sv | 40 ++++
 rtl/multicycle_control_unit.sv | 156 +++++++++++++++
 tb/tb_multicycle_control_unit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle RISC-V control FSM: opcodes, state
// encoding, datapath select codes and the registered control-word layout.
package multicycle_control_unit_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC     = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       trap;
  } ctrl_t;

  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory bundle. The master side is the control FSM.
interface multicycle_control_unit_if #(
  parameter int unsigned OPCODE_W = 7
);
  // Memory handshake: in FETCH/MEM_RD/MEM_WR the request (MemRead or MemWrite)
  // is held stable until a cycle in which mem_ready is sampled high; that cycle
  // completes the access. mem_ready is ignored in every other state.
  logic [OPCODE_W-1:0] Opcode;
  logic                mem_ready;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                IorD;
  logic                IRWrite;
  logic                MemRead;
  logic                MemWrite;
  logic                MemtoReg;
  logic                RegWrite;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ALUOp;
  logic [1:0]          PCSource;
  logic                trap;
  logic [3:0]          state_o;

  modport master (
    input  Opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, trap, state_o
  );

  modport slave (
    output Opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, trap, state_o
  );
endinterface

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Counts not-ready cycles spent in a memory state; flags the wait that would
// bring the count to MEM_TIMEOUT (a ready in that same cycle still completes).
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_mem,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waiting;

  assign waiting = in_mem && !mem_ready;

  // Any cycle that is not a wait (completion or non-memory state) clears the
  // count, so every memory state is entered with the counter at zero.
  always_comb begin
    cnt_d   = '0;
    timeout = waiting && (cnt_q == LAST);
    if (waiting) begin
      cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM: fetch/decode/execute/memory/writeback
// sequencing with a ready handshake to variable-latency memory and a sticky trap.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 7,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8,
  parameter bit          JAL_EN      = 1'b1
) (
  input logic                        clk,
  input logic                        reset_n,
  multicycle_control_unit_if.master  bus
);

  state_t              state_q, state_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic [OPCODE_W-1:0] opcode;
  logic                timeout;
  logic                fetch_done;

  assign opcode = bus.Opcode;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_mem    (is_mem_state(state_q)),
    .mem_ready (bus.mem_ready),
    .timeout   (timeout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready)   state_d = S_DECODE;
        else if (timeout)    state_d = S_TRAP;
      end
      S_DECODE: begin
        if (opcode == OP_R || opcode == OP_I)          state_d = S_EXEC;
        else if (opcode == OP_LD || opcode == OP_SD)   state_d = S_MEM_ADDR;
        else if (opcode == OP_BEQ)                     state_d = S_BRANCH;
        else if (opcode == OP_JAL && JAL_EN)           state_d = S_JAL;
        else                                           state_d = S_TRAP;
      end
      S_EXEC:   state_d = S_ALU_WB;
      S_ALU_WB: state_d = S_FETCH;
      S_MEM_ADDR: begin
        if (opcode == OP_LD)       state_d = S_MEM_RD;
        else if (opcode == OP_SD)  state_d = S_MEM_WR;
        else                       state_d = S_TRAP;
      end
      S_MEM_RD: begin
        if (bus.mem_ready)   state_d = S_MEM_WB;
        else if (timeout)    state_d = S_TRAP;
      end
      S_MEM_WB: state_d = S_FETCH;
      S_MEM_WR: begin
        if (bus.mem_ready)   state_d = S_FETCH;
        else if (timeout)    state_d = S_TRAP;
      end
      S_BRANCH: state_d = S_FETCH;
      S_JAL:    state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  // Control word for the state being entered, registered alongside the state.
  // EXEC is only entered from DECODE, where the IR-held opcode is stable.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.alu_src_b = SRCB_FOUR;
        ctrl_d.alu_op    = ALUOP_ADD;
        ctrl_d.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.alu_op    = ALUOP_ADD;
      end
      S_EXEC: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = (opcode == OP_R) ? SRCB_RS2 : SRCB_IMM;
        ctrl_d.alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: ctrl_d.reg_write = 1'b1;
      S_MEM_ADDR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.iord      = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_src_b     = SRCB_RS2;
        ctrl_d.alu_op        = ALUOP_SUB;
        ctrl_d.pc_write_cond = 1'b1;
        ctrl_d.pc_source     = PCSRC_ALUOUT;
      end
      S_JAL: begin
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.pc_source = PCSRC_JUMP;
        ctrl_d.reg_write = 1'b1;
      end
      S_TRAP:  ctrl_d.trap = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // IR latch and PC+4 happen in the cycle the fetch completes, not a cycle later.
  assign fetch_done = (state_q == S_FETCH) && bus.mem_ready;

  assign bus.PCWrite     = ctrl_q.pc_write | fetch_done;
  assign bus.IRWrite     = fetch_done;
  assign bus.PCWriteCond = ctrl_q.pc_write_cond;
  assign bus.IorD        = ctrl_q.iord;
  assign bus.MemRead     = ctrl_q.mem_read;
  assign bus.MemWrite    = ctrl_q.mem_write;
  assign bus.MemtoReg    = ctrl_q.mem_to_reg;
  assign bus.RegWrite    = ctrl_q.reg_write;
  assign bus.ALUSrcA     = ctrl_q.alu_src_a;
  assign bus.ALUSrcB     = ctrl_q.alu_src_b;
  assign bus.ALUOp       = ctrl_q.alu_op;
  assign bus.PCSource    = ctrl_q.pc_source;
  assign bus.trap        = ctrl_q.trap;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: each step names the state expected after a clock edge; the
// full control word for that state is queued and checked by per-DUT monitors.
module tb_multicycle_control_unit;
  import multicycle_control_unit_pkg::*;

  localparam int W = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       mem_ready;
  logic [6:0] opcode;
  string      phase;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  logic [W-1:0] exp_nj_q[$];
  string        tag_nj_q[$];

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OPCODE_W(7)) bus ();
  multicycle_control_unit_if #(.OPCODE_W(7)) bus_nj ();

  assign bus.Opcode       = opcode;
  assign bus.mem_ready    = mem_ready;
  assign bus_nj.Opcode    = opcode;
  assign bus_nj.mem_ready = mem_ready;

  multicycle_control_unit #(
    .OPCODE_W(7), .MEM_TIMEOUT(4), .CNT_W(8), .JAL_EN(1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  multicycle_control_unit #(
    .OPCODE_W(7), .MEM_TIMEOUT(4), .CNT_W(8), .JAL_EN(1'b0)
  ) dut_nj (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_nj)
  );

  // Expected control word:
  // {state, trap, PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
  //  MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource}
  function automatic logic [W-1:0] exp_word(state_t st, logic rdy, logic [6:0] op);
    logic trap, pcw, pcwc, iord, irw, mr, mw, m2r, rw, asa;
    logic [1:0] asb, aop, pcs;
    {trap, pcw, pcwc, iord, irw, mr, mw, m2r, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      S_FETCH:    begin mr = 1'b1; asb = 2'b01; pcw = rdy; irw = rdy; end
      S_DECODE:   asb = 2'b10;
      S_EXEC:     begin asa = 1'b1; aop = 2'b10; asb = (op == 7'b0110011) ? 2'b00 : 2'b10; end
      S_ALU_WB:   rw = 1'b1;
      S_MEM_ADDR: begin asa = 1'b1; asb = 2'b10; end
      S_MEM_RD:   begin mr = 1'b1; iord = 1'b1; end
      S_MEM_WB:   begin rw = 1'b1; m2r = 1'b1; end
      S_MEM_WR:   begin mw = 1'b1; iord = 1'b1; end
      S_BRANCH:   begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      S_JAL:      begin pcw = 1'b1; pcs = 2'b10; rw = 1'b1; end
      S_TRAP:     trap = 1'b1;
      default:    trap = 1'b0;
    endcase
    return {4'(st), trap, pcw, pcwc, iord, irw, mr, mw, m2r, rw, asa, asb, aop, pcs};
  endfunction

  // After the next edge the DUT must be in st (dut_nj in st_nj when chk_nj);
  // rn/rdy are then applied for that cycle.
  task automatic step2(input logic rn, input logic rdy, input state_t st,
                       input state_t st_nj, input bit chk_nj);
    @(posedge clk);
    #1;
    reset_n   = rn;
    mem_ready = rdy;
    exp_q.push_back(exp_word(st, rdy, opcode));
    tag_q.push_back($sformatf("%s/%s", phase, st.name()));
    if (chk_nj) begin
      exp_nj_q.push_back(exp_word(st_nj, rdy, opcode));
      tag_nj_q.push_back($sformatf("nojal_%s/%s", phase, st_nj.name()));
    end
  endtask

  task automatic step(input logic rn, input logic rdy, input state_t st);
    step2(rn, rdy, st, S_IDLE, 1'b0);
  endtask

  logic [W-1:0] got_m, want_m, got_n, want_n;
  string        tg_m, tg_n;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      want_m = exp_q.pop_front();
      tg_m   = tag_q.pop_front();
      got_m  = {bus.state_o, bus.trap, bus.PCWrite, bus.PCWriteCond, bus.IorD,
                bus.IRWrite, bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.RegWrite,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource};
      n_tests++;
      if (got_m !== want_m) begin
        n_fail++;
        $display("FAIL %s: got %05h required %05h", tg_m, got_m, want_m);
      end
    end
  end

  always @(negedge clk) begin
    if (exp_nj_q.size() > 0) begin
      want_n = exp_nj_q.pop_front();
      tg_n   = tag_nj_q.pop_front();
      got_n  = {bus_nj.state_o, bus_nj.trap, bus_nj.PCWrite, bus_nj.PCWriteCond,
                bus_nj.IorD, bus_nj.IRWrite, bus_nj.MemRead, bus_nj.MemWrite,
                bus_nj.MemtoReg, bus_nj.RegWrite, bus_nj.ALUSrcA, bus_nj.ALUSrcB,
                bus_nj.ALUOp, bus_nj.PCSource};
      n_tests++;
      if (got_n !== want_n) begin
        n_fail++;
        $display("FAIL %s: got %05h required %05h", tg_n, got_n, want_n);
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    opcode    = OP_JAL;

    phase = "reset";
    step2(1'b0, 1'b0, S_IDLE, S_IDLE, 1'b1);
    step2(1'b1, 1'b1, S_IDLE, S_IDLE, 1'b1);

    phase = "jal";
    step2(1'b1, 1'b1, S_FETCH,  S_FETCH,  1'b1);
    step2(1'b1, 1'b1, S_DECODE, S_DECODE, 1'b1);
    step2(1'b1, 1'b1, S_JAL,    S_TRAP,   1'b1);
    step2(1'b1, 1'b1, S_FETCH,  S_TRAP,   1'b1);
    opcode = OP_R;

    phase = "rtype";
    step(1'b1, 1'b1, S_DECODE);
    step(1'b1, 1'b1, S_EXEC);
    step(1'b1, 1'b1, S_ALU_WB);
    step(1'b1, 1'b0, S_FETCH);

    phase = "fetch_wait";
    step(1'b1, 1'b0, S_FETCH);
    step(1'b1, 1'b1, S_FETCH);
    opcode = OP_I;

    phase = "itype";
    step(1'b1, 1'b1, S_DECODE);
    step(1'b1, 1'b1, S_EXEC);
    step(1'b1, 1'b1, S_ALU_WB);
    step(1'b1, 1'b1, S_FETCH);
    opcode = OP_BEQ;

    phase = "beq";
    step(1'b1, 1'b1, S_DECODE);
    step(1'b1, 1'b1, S_BRANCH);
    step(1'b1, 1'b1, S_FETCH);
    opcode = OP_LD;

    phase = "ld_wait3";
    step(1'b1, 1'b1, S_DECODE);
    step(1'b1, 1'b0, S_MEM_ADDR);
    step(1'b1, 1'b0, S_MEM_RD);
    step(1'b1, 1'b0, S_MEM_RD);
    step(1'b1, 1'b0, S_MEM_RD);
    step(1'b1, 1'b1, S_MEM_RD);
    step(1'b1, 1'b0, S_MEM_WB);
    step(1'b1, 1'b1, S_FETCH);
    opcode = OP_SD;

    phase = "sd_zero_wait";
    step(1'b1, 1'b0, S_DECODE);
    step(1'b1, 1'b1, S_MEM_ADDR);
    step(1'b1, 1'b1, S_MEM_WR);
    step(1'b1, 1'b1, S_FETCH);

    phase = "sd_ready_at_limit";
    step(1'b1, 1'b1, S_DECODE);
    step(1'b1, 1'b0, S_MEM_ADDR);
    step(1'b1, 1'b0, S_MEM_WR);
    step(1'b1, 1'b0, S_MEM_WR);
    step(1'b1, 1'b0, S_MEM_WR);
    step(1'b1, 1'b1, S_MEM_WR);
    step(1'b1, 1'b1, S_FETCH);

    phase = "sd_reset_abort";
    step(1'b1, 1'b1, S_DECODE);
    step(1'b1, 1'b0, S_MEM_ADDR);
    step(1'b1, 1'b0, S_MEM_WR);
    step(1'b0, 1'b0, S_MEM_WR);
    step(1'b1, 1'b1, S_IDLE);
    step(1'b1, 1'b1, S_FETCH);

    phase = "sd_timeout";
    step(1'b1, 1'b0, S_DECODE);
    step(1'b1, 1'b0, S_MEM_ADDR);
    step(1'b1, 1'b0, S_MEM_WR);
    step(1'b1, 1'b0, S_MEM_WR);
    step(1'b1, 1'b0, S_MEM_WR);
    step(1'b1, 1'b0, S_MEM_WR);
    step(1'b1, 1'b1, S_TRAP);
    step(1'b1, 1'b1, S_TRAP);
    step(1'b0, 1'b0, S_TRAP);
    step(1'b1, 1'b1, S_IDLE);
    step(1'b1, 1'b1, S_FETCH);
    opcode = 7'b1111111;

    phase = "illegal";
    step(1'b1, 1'b1, S_DECODE);
    step(1'b1, 1'b1, S_TRAP);
    step(1'b1, 1'b1, S_TRAP);
    step(1'b0, 1'b1, S_TRAP);
    step(1'b1, 1'b1, S_IDLE);
    step(1'b1, 1'b1, S_FETCH);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0 || exp_nj_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d/%0d entries left, required 0/0",
               exp_q.size(), exp_nj_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
